// File: rtl/seg7_pkg.sv
// Shared types, segment codes and the digit encoder for the seven-segment value display.
package seg7_pkg;

    localparam int unsigned VALUE_W = 8;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned Q_W     = 3 * SEG_W;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t hundreds;
        bcd_t tens;
        bcd_t ones;
    } bcd3_t;

    // Active-high gfedcba codes
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
    localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;

    function automatic logic [SEG_W-1:0] seg7_encode(input bcd_t digit, input logic blank,
                                                     input logic active_low);
        logic [SEG_W-1:0] s;
        case (digit)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        if (blank) s = SEG_BLANK;
        return active_low ? ~s : s;
    endfunction

endpackage

// File: rtl/seg7_value_display_if.sv
// Value/blank request and segment/status response bundle of the display back-end.
interface seg7_value_display_if;
    import seg7_pkg::*;

    logic [VALUE_W-1:0] value_i;
    logic               blank_i;
    logic [Q_W-1:0]     Q_o;
    logic               busy_o;
    logic               done_o;

    modport master (output value_i, output blank_i, input Q_o, input busy_o, input done_o);
    modport slave  (input value_i, input blank_i, output Q_o, output busy_o, output done_o);

endinterface

// File: rtl/bin2bcd_serial.sv
// Iterative shift-add-3 binary to 3-digit BCD converter; re-converts only on a changed input.
module bin2bcd_serial
    import seg7_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [VALUE_W-1:0] value,
    output logic               busy,
    output logic               done,
    output bcd3_t              digit_q
);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t             state;
    logic [VALUE_W-1:0] last_q;
    logic [VALUE_W-1:0] bin_q;
    logic [11:0]        bcd_q;
    logic [2:0]         iter_q;
    logic [11:0]        bcd_adj;
    logic [19:0]        shifted;

    function automatic logic [11:0] add3(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < 3; i++) begin
            if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    // One double-dabble iteration: correct nibbles, then shift {bcd, bin} left
    always_comb begin
        bcd_adj = add3(bcd_q);
        shifted = {bcd_adj[10:0], bin_q, 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last_q  <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            iter_q  <= '0;
            digit_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (value != last_q) begin
                        last_q <= value;
                        bin_q  <= value;
                        bcd_q  <= '0;
                        iter_q <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_q  <= shifted[19:8];
                    bin_q  <= shifted[7:0];
                    iter_q <= iter_q + 3'd1;
                    if (iter_q == 3'd7) state <= LOAD;
                end
                LOAD: begin
                    digit_q <= bcd3_t'(bcd_q);
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/seg7_value_display.sv
// Display back-end: registers the value, converts it to BCD and drives three seven-segment digits.
module seg7_value_display
    import seg7_pkg::*;
#(
    parameter bit LZ_BLANK       = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    seg7_value_display_if.slave bus
);

    localparam logic [SEG_W-1:0] ZERO_CODE = seg7_encode(4'd0, 1'b0, SEG_ACTIVE_LOW);
    localparam logic [SEG_W-1:0] LEAD_CODE = seg7_encode(4'd0, LZ_BLANK, SEG_ACTIVE_LOW);
    localparam logic [Q_W-1:0]   RESET_Q   = {LEAD_CODE, LEAD_CODE, ZERO_CODE};

    logic [VALUE_W-1:0] value_q;
    bcd3_t              digit_q;
    logic               busy;
    logic               done;
    logic               hund_blank;
    logic               tens_blank;
    logic [Q_W-1:0]     q_next;
    logic [Q_W-1:0]     q_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) value_q <= '0;
        else       value_q <= bus.value_i;
    end

    bin2bcd_serial u_bcd (
        .clk     (clk_i),
        .rst     (rst_i),
        .value   (value_q),
        .busy    (busy),
        .done    (done),
        .digit_q (digit_q)
    );

    // Leading-zero suppression; the ones digit always stays lit
    always_comb begin
        hund_blank = LZ_BLANK && (digit_q.hundreds == 4'd0);
        tens_blank = hund_blank && (digit_q.tens == 4'd0);
        q_next = {seg7_encode(digit_q.hundreds, hund_blank || bus.blank_i, SEG_ACTIVE_LOW),
                  seg7_encode(digit_q.tens,     tens_blank || bus.blank_i, SEG_ACTIVE_LOW),
                  seg7_encode(digit_q.ones,     bus.blank_i,               SEG_ACTIVE_LOW)};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) q_reg <= RESET_Q;
        else       q_reg <= q_next;
    end

    assign bus.Q_o    = q_reg;
    assign bus.busy_o = busy;
    assign bus.done_o = done;

endmodule

// File: tb/tb_seg7_value_display.sv
// Self-checking bench for seg7_value_display against a decimal-arithmetic display model.
module tb_seg7_value_display;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   prev_v = 0;

    seg7_value_display_if bus ();
    seg7_value_display_if bus_nz ();

    assign bus_nz.value_i = bus.value_i;
    assign bus_nz.blank_i = bus.blank_i;

    seg7_value_display dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    seg7_value_display #(.LZ_BLANK(1'b0)) dut_nz (.clk_i(clk), .rst_i(rst), .bus(bus_nz));

    always #10 clk = ~clk;

    // Expected segments from decimal digits of v (active-low output)
    function automatic logic [20:0] model(input int v, input bit lz, input bit blk);
        logic [6:0] tbl [0:9];
        logic [6:0] ch, ct, co;
        int h, t, o;
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        ch = (blk || (lz && h == 0)) ? 7'h00 : tbl[h];
        ct = (blk || (lz && v < 10)) ? 7'h00 : tbl[t];
        co = blk ? 7'h00 : tbl[o];
        return {~ch, ~ct, ~co};
    endfunction

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int v, input int cycles);
        bus.value_i = 8'(v);
        repeat (cycles) wait_edge();
        prev_v = v;
    endtask

    task automatic test_reset();
        int dones;
        rst = 1'b1;
        bus.value_i = 8'd0;
        bus.blank_i = 1'b0;
        repeat (2) wait_edge();
        rst = 1'b0;
        n_cmp++;
        if (bus.Q_o !== model(0, 1, 0)) begin
            n_err++; $display("FAIL reset_q: got %h expected %h", bus.Q_o, model(0, 1, 0));
        end
        n_cmp++;
        if (bus_nz.Q_o !== model(0, 0, 0)) begin
            n_err++; $display("FAIL reset_q_nz: got %h expected %h", bus_nz.Q_o, model(0, 0, 0));
        end
        n_cmp++;
        if (bus.busy_o !== 1'b0) begin
            n_err++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o);
        end
        dones = 0;
        repeat (20) begin
            wait_edge();
            if (bus.done_o === 1'b1) dones++;
        end
        n_cmp++;
        if (dones != 0) begin
            n_err++; $display("FAIL idle_no_done: got %0d pulses expected 0", dones);
        end
        prev_v = 0;
    endtask

    task automatic test_latency();
        int first_done, dones;
        logic [20:0] q_at11, q_at12;
        logic busy_at2;
        first_done = -1; dones = 0; busy_at2 = 1'b0; q_at11 = '0; q_at12 = '0;
        bus.value_i = 8'd255;
        for (int n = 1; n <= 14; n++) begin
            wait_edge();
            if (bus.done_o === 1'b1) begin
                dones++;
                if (first_done < 0) first_done = n;
            end
            if (n == 2)  busy_at2 = bus.busy_o;
            if (n == 11) q_at11 = bus.Q_o;
            if (n == 12) q_at12 = bus.Q_o;
        end
        prev_v = 255;
        n_cmp++;
        if (first_done != 11) begin
            n_err++; $display("FAIL done_latency: got edge %0d expected edge 11", first_done);
        end
        n_cmp++;
        if (dones != 1) begin
            n_err++; $display("FAIL done_pulse_count: got %0d expected 1", dones);
        end
        n_cmp++;
        if (busy_at2 !== 1'b1) begin
            n_err++; $display("FAIL busy_start: got %b expected 1", busy_at2);
        end
        n_cmp++;
        if (q_at11 !== model(0, 1, 0)) begin
            n_err++; $display("FAIL q_before_update: got %h expected %h", q_at11, model(0, 1, 0));
        end
        n_cmp++;
        if (q_at12 !== model(255, 1, 0)) begin
            n_err++; $display("FAIL q_255: got %h expected %h", q_at12, model(255, 1, 0));
        end
    endtask

    task automatic test_values();
        int vals [3];
        vals = '{7, 100, 10};
        foreach (vals[i]) begin
            settle(vals[i], 20);
            n_cmp++;
            if (bus.Q_o !== model(vals[i], 1, 0)) begin
                n_err++; $display("FAIL q_value_%0d: got %h expected %h", vals[i], bus.Q_o, model(vals[i], 1, 0));
            end
            n_cmp++;
            if (bus_nz.Q_o !== model(vals[i], 0, 0)) begin
                n_err++; $display("FAIL q_nz_value_%0d: got %h expected %h", vals[i], bus_nz.Q_o, model(vals[i], 0, 0));
            end
        end
    endtask

    task automatic wait_done(input int max_edges, output int taken, output bit ok);
        ok = 1'b0;
        taken = 0;
        while (!ok && taken < max_edges) begin
            wait_edge();
            taken++;
            if (bus.done_o === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        bit ok1, ok2;
        bus.value_i = 8'd200;
        repeat (3) wait_edge();
        bus.value_i = 8'd37;
        wait_done(30, t1, ok1);
        t1 += 3;
        wait_edge();
        n_cmp++;
        if (!ok1 || bus.Q_o !== model(200, 1, 0)) begin
            n_err++; $display("FAIL b2b_first: got %h expected %h (done seen %b)", bus.Q_o, model(200, 1, 0), ok1);
        end
        wait_done(30, t2, ok2);
        t2 += 1;
        wait_edge();
        n_cmp++;
        if (!ok2 || bus.Q_o !== model(37, 1, 0)) begin
            n_err++; $display("FAIL b2b_final: got %h expected %h (done seen %b)", bus.Q_o, model(37, 1, 0), ok2);
        end
        n_cmp++;
        if (t2 != 10) begin
            n_err++; $display("FAIL b2b_spacing: got %0d cycles expected 10", t2);
        end
        prev_v = 37;
    endtask

    task automatic test_blank();
        int t;
        bit ok;
        settle(128, 20);
        bus.value_i = 8'd99;
        repeat (4) wait_edge();
        bus.blank_i = 1'b1;
        wait_edge();
        n_cmp++;
        if (bus.Q_o !== model(99, 1, 1)) begin
            n_err++; $display("FAIL blank_assert: got %h expected %h", bus.Q_o, model(99, 1, 1));
        end
        wait_done(30, t, ok);
        n_cmp++;
        if (!ok) begin
            n_err++; $display("FAIL blank_conversion_done: got no done expected done");
        end
        repeat (2) wait_edge();
        n_cmp++;
        if (bus.Q_o !== model(99, 1, 1)) begin
            n_err++; $display("FAIL blank_hold: got %h expected %h", bus.Q_o, model(99, 1, 1));
        end
        bus.blank_i = 1'b0;
        wait_edge();
        n_cmp++;
        if (bus.Q_o !== model(99, 1, 0)) begin
            n_err++; $display("FAIL blank_release: got %h expected %h", bus.Q_o, model(99, 1, 0));
        end
        prev_v = 99;
    endtask

    task automatic test_reset_mid();
        int dones, first_done;
        logic [20:0] q12;
        dones = 0; first_done = -1; q12 = '0;
        bus.value_i = 8'd150;
        repeat (5) begin
            wait_edge();
            if (bus.done_o === 1'b1) dones++;
        end
        rst = 1'b1;
        wait_edge();
        rst = 1'b0;
        n_cmp++;
        if (bus.Q_o !== model(0, 1, 0) || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            n_err++; $display("FAIL rst_mid: got q=%h busy=%b done=%b expected q=%h busy=0 done=0",
                              bus.Q_o, bus.busy_o, bus.done_o, model(0, 1, 0));
        end
        for (int n = 1; n <= 12; n++) begin
            wait_edge();
            if (bus.done_o === 1'b1 && first_done < 0) first_done = n;
            if (n == 12) q12 = bus.Q_o;
        end
        n_cmp++;
        if (dones != 0 || first_done != 11) begin
            n_err++; $display("FAIL rst_mid_done: got pre-reset %0d, first at %0d expected 0 and 11", dones, first_done);
        end
        n_cmp++;
        if (q12 !== model(150, 1, 0)) begin
            n_err++; $display("FAIL rst_mid_reconvert: got %h expected %h", q12, model(150, 1, 0));
        end
        prev_v = 150;
    endtask

    task automatic test_random();
        int v, dones, want;
        bit blk;
        for (int i = 0; i < 24; i++) begin
            v = int'($urandom_range(0, 255));
            blk = ($urandom_range(0, 5) == 0);
            bus.value_i = 8'(v);
            bus.blank_i = blk;
            dones = 0;
            repeat (12) begin
                wait_edge();
                if (bus.done_o === 1'b1) dones++;
            end
            want = (v != prev_v) ? 1 : 0;
            prev_v = v;
            n_cmp++;
            if (bus.Q_o !== model(v, 1, blk) || bus_nz.Q_o !== model(v, 0, blk)) begin
                n_err++; $display("FAIL rand_q_%0d: got %h/%h expected %h/%h", v, bus.Q_o, bus_nz.Q_o,
                                  model(v, 1, blk), model(v, 0, blk));
            end
            n_cmp++;
            if (dones != want) begin
                n_err++; $display("FAIL rand_done_%0d: got %0d expected %0d", v, dones, want);
            end
        end
        bus.blank_i = 1'b0;
    endtask

    initial begin
        bus.value_i = 8'd0;
        bus.blank_i = 1'b0;
        test_reset();
        test_latency();
        test_values();
        test_back_to_back();
        test_blank();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
